lustre_seq_compare: RTL and testbench

- Multi-cycle, multi-mode integer comparator for the Lustre stdlib.
- Successor to the single-cycle unsigned less-than: adds signed/unsigned selection, six relational modes and chunked evaluation (CHUNK bits per cycle) for wide operands.
- Valid/ready handshake on both sides, so compiled Lustre nodes can use it for wide comparisons where a single-cycle full-width carry chain breaks timing.

---
 rtl/lustre_seq_compare_pkg.sv | 34 +++
 rtl/lustre_seq_compare_if.sv | 18 +
 rtl/lustre_seq_compare_adder.sv | 21 ++
 rtl/lustre_seq_compare.sv | 88 ++++++++
 tb/tb_lustre_seq_compare.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/lustre_seq_compare_pkg.sv
// lustre_seq_compare_pkg: shared mode codes, FSM state encodings and result decode for the chunked comparator
package lustre_seq_compare_pkg;

   typedef enum logic [2:0] {
      MODE_EQ = 3'd0,
      MODE_NE = 3'd1,
      MODE_LT = 3'd2,
      MODE_LE = 3'd3,
      MODE_GT = 3'd4,
      MODE_GE = 3'd5
   } cmp_mode_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int idx_width(input int nc);
      return nc > 1 ? $clog2(nc) : 1;
   endfunction

   // Reserved codes 6 and 7 fall through to 0.
   function automatic logic cmp_result(input logic [2:0] mode, input logic sgn, input logic c,
                                       input logic z, input logic nf, input logic v);
      logic lt;
      lt = sgn ? nf ^ v : ~c;
      return mode == MODE_EQ ? z :
             mode == MODE_NE ? ~z :
             mode == MODE_LT ? lt :
             mode == MODE_LE ? lt | z :
             mode == MODE_GT ? ~lt & ~z :
             mode == MODE_GE ? ~lt : 1'b0;
   endfunction

endpackage

// File: rtl/lustre_seq_compare_if.sv
// lustre_seq_compare_if: request/response handshake bundle for the chunked comparator
interface lustre_seq_compare_if
   import lustre_seq_compare_pkg::*;
#(parameter int N = 8);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] lhs;
   logic [N-1:0] rhs;
   logic [2:0]   mode;
   logic         is_signed;
   logic         out_valid;
   logic         out_ready;
   logic         res;
   modport master (output in_valid, lhs, rhs, mode, is_signed, out_ready,
                   input  in_ready, out_valid, res);
   modport slave  (input  in_valid, lhs, rhs, mode, is_signed, out_ready,
                   output in_ready, out_valid, res);
endinterface

// File: rtl/lustre_seq_compare_adder.sv
// internal_lustre_adder: N-bit adder with carry-in exposing Z/C/N/V flags
module internal_lustre_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         carry_in,
   output logic [N-1:0] res,
   output logic         flag_Z,
   output logic         flag_C,
   output logic         flag_N,
   output logic         flag_V
);
   logic [N:0] sum;
   assign sum    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};
   assign res    = sum[N-1:0];
   assign flag_C = sum[N];
   assign flag_Z = ~|sum[N-1:0];
   assign flag_N = sum[N-1];
   assign flag_V = (a[N-1] == b[N-1]) & (sum[N-1] != a[N-1]);
endmodule

// File: rtl/lustre_seq_compare.sv
// lustre_seq_compare: multi-cycle signed/unsigned six-mode comparator, CHUNK bits of lhs - rhs per cycle
module lustre_seq_compare
   import lustre_seq_compare_pkg::*;
#(
   parameter int N     = 8,
   parameter int CHUNK = 4
) (
   input logic              clock,
   input logic              reset,
   lustre_seq_compare_if.slave bus
);
   localparam int NC = N / CHUNK;
   localparam int IW = idx_width(NC);
   localparam logic [IW-1:0] LAST = IW'(NC - 1);

   if (CHUNK < 1 || CHUNK > N || N % CHUNK != 0) begin : g_bad_chunk
      $error("lustre_seq_compare: CHUNK must be in 1..N and divide N");
   end

   logic [1:0]       state;
   logic [N-1:0]     lhs_q;
   logic [N-1:0]     rhs_n_q;
   logic [2:0]       mode_q;
   logic             sgn_q;
   logic             carry;
   logic             zacc;
   logic [IW-1:0]    idx;
   logic             res_q;
   logic [CHUNK-1:0] chunk_sum;
   logic             unused_sum;
   logic             flag_z;
   logic             flag_c;
   logic             flag_n;
   logic             flag_v;

   internal_lustre_adder #(.N(CHUNK)) u_adder (
      .a        (lhs_q[CHUNK*int'(idx) +: CHUNK]),
      .b        (rhs_n_q[CHUNK*int'(idx) +: CHUNK]),
      .carry_in (carry),
      .res      (chunk_sum),
      .flag_Z   (flag_z),
      .flag_C   (flag_c),
      .flag_N   (flag_n),
      .flag_V   (flag_v)
   );

   assign unused_sum    = ^chunk_sum;
   assign bus.in_ready  = state == ST_IDLE;
   assign bus.out_valid = state == ST_DONE;
   assign bus.res       = res_q;

   // Accept in IDLE, walk the chunks LSB first in RUN, hold the result in DONE until consumed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         lhs_q   <= '0;
         rhs_n_q <= '0;
         mode_q  <= '0;
         sgn_q   <= 1'b0;
         carry   <= 1'b1;
         zacc    <= 1'b1;
         idx     <= '0;
         res_q   <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (bus.in_valid) begin
            lhs_q   <= bus.lhs;
            rhs_n_q <= ~bus.rhs;
            mode_q  <= bus.mode;
            sgn_q   <= bus.is_signed;
            carry   <= 1'b1;
            zacc    <= 1'b1;
            idx     <= '0;
            state   <= ST_RUN;
         end
      end else if (state == ST_RUN) begin
         carry <= flag_c;
         zacc  <= zacc & flag_z;
         if (idx == LAST) begin
            res_q <= cmp_result(mode_q, sgn_q, flag_c, zacc & flag_z, flag_n, flag_v);
            state <= ST_DONE;
         end else begin
            idx <= idx + 1'b1;
         end
      end else if (bus.out_ready) begin
         state <= ST_IDLE;
      end
   end
endmodule

// File: tb/tb_lustre_seq_compare.sv
// tb_lustre_seq_compare: scoreboard bench for three chunkings of the sequential comparator
module tb_lustre_seq_compare;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] lhs, rhs;
   logic [2:0] mode;
   logic       sgn;
   logic [2:0] vld = '0;
   logic [2:0] rdy = '0;
   logic [2:0] ir, ov, rs;
   int         checks = 0;
   int         errors = 0;

   typedef struct {int k; logic r;} exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   lustre_seq_compare_if #(.N(8)) i4 ();
   lustre_seq_compare_if #(.N(8)) i8 ();
   lustre_seq_compare_if #(.N(8)) i1 ();

   assign i4.lhs = lhs; assign i4.rhs = rhs; assign i4.mode = mode; assign i4.is_signed = sgn;
   assign i8.lhs = lhs; assign i8.rhs = rhs; assign i8.mode = mode; assign i8.is_signed = sgn;
   assign i1.lhs = lhs; assign i1.rhs = rhs; assign i1.mode = mode; assign i1.is_signed = sgn;
   assign i4.in_valid = vld[0]; assign i4.out_ready = rdy[0];
   assign i8.in_valid = vld[1]; assign i8.out_ready = rdy[1];
   assign i1.in_valid = vld[2]; assign i1.out_ready = rdy[2];
   assign ir = {i1.in_ready, i8.in_ready, i4.in_ready};
   assign ov = {i1.out_valid, i8.out_valid, i4.out_valid};
   assign rs = {i1.res, i8.res, i4.res};

   lustre_seq_compare #(.N(8), .CHUNK(4)) u4 (.clock(clk), .reset(rst), .bus(i4));
   lustre_seq_compare #(.N(8), .CHUNK(8)) u8 (.clock(clk), .reset(rst), .bus(i8));
   lustre_seq_compare #(.N(8), .CHUNK(1)) u1 (.clock(clk), .reset(rst), .bus(i1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m, input logic s);
      logic lt, eq;
      eq = a == b;
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      case (m)
         3'd0: return eq;
         3'd1: return !eq;
         3'd2: return lt;
         3'd3: return lt | eq;
         3'd4: return !lt & !eq;
         3'd5: return !lt;
         default: return 1'b0;
      endcase
   endfunction

   // Completed handshakes are matched against the scoreboard in order.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ov[k] && rdy[k]) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'(k), 32'hFFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("result_dut", 32'(k), 32'(e.k));
               check("res", 32'(rs[k]), 32'(e.r));
            end
         end
      end
   end

   task automatic start_op(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] m, input logic s);
      check("in_ready_idle", 32'(ir[k]), 32'd1);
      lhs = a; rhs = b; mode = m; sgn = s; vld[k] = 1'b1;
      exp_q.push_back('{k, model(a, b, m, s)});
      @(posedge clk); #1;
      vld[k] = 1'b0;
      lhs = 8'($urandom); rhs = 8'($urandom); mode = 3'($urandom); sgn = 1'($urandom);
   endtask

   task automatic wait_done(input int k, input int lat);
      int n = 0;
      while (!ov[k] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'(lat));
   endtask

   task automatic consume(input int k);
      rdy[k] = 1'b1;
      @(posedge clk); #1;
      rdy[k] = 1'b0;
      check("in_ready_after", 32'(ir[k]), 32'd1);
      check("out_valid_after", 32'(ov[k]), 32'd0);
   endtask

   task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] m, input logic s, input int lat);
      start_op(k, a, b, m, s);
      wait_done(k, lat);
      consume(k);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp_hold;
      logic [7:0] a, b;
      lhs = '0; rhs = '0; mode = '0; sgn = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_in_ready", 32'(ir[k]), 32'd1);
         check("rst_out_valid", 32'(ov[k]), 32'd0);
         check("rst_res", 32'(rs[k]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(0, 8'd3, 8'd5, 3'd2, 1'b0, 2);
      run_op(0, 8'd3, 8'd5, 3'd5, 1'b0, 2);
      run_op(0, 8'h80, 8'h01, 3'd2, 1'b1, 2);
      run_op(0, 8'h80, 8'h01, 3'd2, 1'b0, 2);
      run_op(0, 8'h80, 8'h01, 3'd4, 1'b0, 2);
      run_op(0, 8'hA5, 8'hA5, 3'd0, 1'b0, 2);
      run_op(0, 8'hA5, 8'hA5, 3'd3, 1'b0, 2);
      run_op(0, 8'hA5, 8'hA5, 3'd2, 1'b0, 2);
      run_op(0, 8'h50, 8'h05, 3'd0, 1'b0, 2);
      run_op(0, 8'h15, 8'h05, 3'd0, 1'b0, 2);
      run_op(0, 8'h51, 8'h50, 3'd0, 1'b1, 2);
      run_op(0, 8'h51, 8'h50, 3'd1, 1'b0, 2);
      run_op(0, 8'hA5, 8'hA5, 3'd6, 1'b0, 2);
      run_op(0, 8'h01, 8'h02, 3'd7, 1'b1, 2);
      run_op(0, 8'hFE, 8'h01, 3'd3, 1'b1, 2);
      run_op(0, 8'h01, 8'hFE, 3'd5, 1'b1, 2);
      for (int i = 0; i < 12; i++) begin
         a = 8'($urandom);
         b = (i % 4 == 0) ? a : 8'($urandom);
         run_op(0, a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2);
      end
      // Hold the result in DONE while in_valid toggles with fresh operands.
      exp_hold = model(8'h10, 8'h20, 3'd4, 1'b0);
      start_op(0, 8'h10, 8'h20, 3'd4, 1'b0);
      wait_done(0, 2);
      for (int i = 0; i < 5; i++) begin
         vld[0] = ~vld[0];
         lhs = 8'($urandom); rhs = 8'($urandom); mode = 3'd1;
         check("hold_out_valid", 32'(ov[0]), 32'd1);
         check("hold_res", 32'(rs[0]), 32'(exp_hold));
         check("hold_in_ready", 32'(ir[0]), 32'd0);
         @(posedge clk); #1;
      end
      vld[0] = 1'b0;
      consume(0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("no_extra_accept", 32'(ov[0]), 32'd0);
         check("idle_in_ready", 32'(ir[0]), 32'd1);
      end
      // Reset during RUN aborts the operation with no result.
      lhs = 8'd1; rhs = 8'd2; mode = 3'd2; sgn = 1'b0; vld[0] = 1'b1;
      @(posedge clk); #1;
      vld[0] = 1'b0;
      check("run_in_ready", 32'(ir[0]), 32'd0);
      rst = 1'b1;
      #1;
      check("abort_in_ready", 32'(ir[0]), 32'd1);
      check("abort_out_valid", 32'(ov[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rdy[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("abort_no_result", 32'(ov[0]), 32'd0);
      end
      rdy[0] = 1'b0;
      run_op(1, 8'h7F, 8'h80, 3'd4, 1'b1, 1);
      run_op(1, 8'h7F, 8'h80, 3'd4, 1'b0, 1);
      run_op(2, 8'hFF, 8'hFF, 3'd3, 1'b0, 8);
      run_op(2, 8'h80, 8'h7F, 3'd2, 1'b1, 8);
      for (int i = 0; i < 4; i++) begin
         a = 8'($urandom);
         b = (i == 0) ? a : 8'($urandom);
         run_op(1, a, b, 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1);
         run_op(2, a, b, 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 8);
      end
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
